pulse_width_meter: RTL and testbench

Upstream front end of the photonic-switch control path. Measures the high time of an asynchronous control pulse in 200 MHz core-clock cycles and publishes it as the 13-bit width word W. When the measured width changes, it issues a one-cycle start strobe that drives the decoder's `reset` input, so the A/B decode and the downstream PWM generation only restart when the commanded width actually changes.

---
 rtl/pulse_width_meter.sv | 118 +++++++++++
 tb/tb_pulse_width_meter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_meter.sv
// Measures the synchronized high time of pulse_in in clk cycles and publishes it on W.
// A one-cycle start strobe is issued only when the accepted width changes.
module pulse_width_meter #(
  parameter int WIDTH       = 13,
  parameter int MIN_WIDTH   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] W,
  output logic             start,
  output logic             valid,
  output logic             busy,
  output logic             ovf,
  output logic             runt
);

  typedef enum logic [1:0] {ARM, IDLE, MEASURE} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_WIDTH);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ps_d_q, ps_d_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [WIDTH-1:0]       w_q, w_d;
  logic                   start_q, start_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   runt_q, runt_d;
  logic                   ps, rise, fall;

  assign ps   = sync_q[SYNC_STAGES-1];
  assign rise = ps & ~ps_d_q;
  assign fall = ~ps & ps_d_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pulse_in};
    ps_d_d  = ps;
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    w_d     = w_q;
    valid_d = valid_q;
    start_d = 1'b0;
    ovf_d   = 1'b0;
    runt_d  = 1'b0;
    case (state_q)
      ARM: begin
        if (!ps) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          cnt_d   = WIDTH'(1);
          sat_d   = 1'b0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_d = IDLE;
          if (sat_q) begin
            ovf_d = 1'b1;
          end else if (cnt_q < MIN_W) begin
            runt_d = 1'b1;
          end else if (!valid_q || (cnt_q != w_q)) begin
            w_d     = cnt_q;
            start_d = 1'b1;
            valid_d = 1'b1;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          sat_d = 1'b1;
        end
      end
      default: state_d = ARM;
    endcase
  end

  // Synchronizer resets high so ARM needs a genuine low before any rise can be seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      ps_d_q  <= 1'b1;
      state_q <= ARM;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      w_q     <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      runt_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      ps_d_q  <= ps_d_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      w_q     <= w_d;
      start_q <= start_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      runt_q  <= runt_d;
    end
  end

  assign W     = w_q;
  assign start = start_q;
  assign valid = valid_q;
  assign busy  = (state_q == MEASURE);
  assign ovf   = ovf_q;
  assign runt  = runt_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: drives clock-aligned pulses and checks W and strobes.
`timescale 1ns/1ps
module tb_pulse_width_meter;

  localparam int WIDTH = 13;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pulse_in = 1'b0;
  logic [WIDTH-1:0] w_out;
  logic             start, valid, busy, ovf, runt;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int start_cyc = 0;
  int start_cnt, busy_cnt, ovf_cnt, runt_cnt;

  pulse_width_meter #(.WIDTH(WIDTH), .MIN_WIDTH(2), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(rst_n), .pulse_in(pulse_in), .W(w_out),
    .start(start), .valid(valid), .busy(busy), .ovf(ovf), .runt(runt)
  );

  always #2.5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe/busy monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (start) begin
        start_cnt = start_cnt + 1;
        start_cyc = cyc;
      end
      if (busy) busy_cnt = busy_cnt + 1;
      if (ovf)  ovf_cnt  = ovf_cnt + 1;
      if (runt) runt_cnt = runt_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_mon();
    start_cnt = 0; busy_cnt = 0; ovf_cnt = 0; runt_cnt = 0; start_cyc = 0;
  endtask

  // n clock edges sample pulse_in high, then it drops and the bench waits gap cycles
  task automatic send_pulse(input int n, input int gap);
    @(posedge clk); #1 pulse_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 pulse_in = 1'b0;
    fall_cyc = cyc;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string tag);
    // first edge sampling the low is fall_cyc+1; start must appear within SYNC+2 edges of it
    n_assert++;
    assert ((start_cyc > fall_cyc + 1) && (start_cyc <= fall_cyc + 1 + SYNC + 2)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected<=%0d", tag, start_cyc - fall_cyc - 1, SYNC + 2);
    end
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_W", 32'(w_out), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_start", 32'(start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_runt", 32'(runt), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    clear_mon(); send_pulse(500, 20);
    $display("pulse 500 -> W=%0d start=%0d busy=%0d", w_out, start_cnt, busy_cnt);
    check("p500_W", 32'(w_out), 500);
    check("p500_valid", 32'(valid), 1);
    check("p500_start", start_cnt, 1);
    check("p500_busy", busy_cnt, 500);
    check_latency("p500_lat");

    clear_mon(); send_pulse(500, 20);
    $display("pulse 500 again -> W=%0d start=%0d", w_out, start_cnt);
    check("p500b_start", start_cnt, 0);
    check("p500b_W", 32'(w_out), 500);

    clear_mon(); send_pulse(161, 20);
    $display("pulse 161 -> W=%0d start=%0d", w_out, start_cnt);
    check("p161_W", 32'(w_out), 161);
    check("p161_start", start_cnt, 1);

    clear_mon(); send_pulse(1, 20);
    $display("pulse 1 -> W=%0d runt=%0d start=%0d", w_out, runt_cnt, start_cnt);
    check("p1_runt", runt_cnt, 1);
    check("p1_start", start_cnt, 0);
    check("p1_W", 32'(w_out), 161);
    check("p1_valid", 32'(valid), 1);

    clear_mon(); send_pulse(2, 20);
    $display("pulse 2 -> W=%0d start=%0d", w_out, start_cnt);
    check("p2_W", 32'(w_out), 2);
    check("p2_start", start_cnt, 1);
    check("p2_runt", runt_cnt, 0);

    clear_mon(); send_pulse(3, 1); send_pulse(4, 20);
    $display("pulses 3,4 gap1 -> W=%0d start=%0d", w_out, start_cnt);
    check("gap_W", 32'(w_out), 4);
    check("gap_start", start_cnt, 2);

    clear_mon(); send_pulse(8191, 20);
    $display("pulse 8191 -> W=%0d start=%0d ovf=%0d", w_out, start_cnt, ovf_cnt);
    check("p8191_W", 32'(w_out), 8191);
    check("p8191_start", start_cnt, 1);
    check("p8191_ovf", ovf_cnt, 0);

    clear_mon(); send_pulse(8192, 20);
    $display("pulse 8192 -> W=%0d ovf=%0d start=%0d", w_out, ovf_cnt, start_cnt);
    check("p8192_ovf", ovf_cnt, 1);
    check("p8192_W", 32'(w_out), 8191);
    check("p8192_start", start_cnt, 0);

    clear_mon(); send_pulse(10000, 20);
    $display("pulse 10000 -> W=%0d ovf=%0d", w_out, ovf_cnt);
    check("p10000_ovf", ovf_cnt, 1);
    check("p10000_W", 32'(w_out), 8191);

    // pulse already high while reset releases
    @(posedge clk); #1 pulse_in = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (300) @(posedge clk);
    #1 pulse_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("held-high through reset -> W=%0d valid=%0d start=%0d busy=%0d", w_out, valid, start_cnt, busy_cnt);
    check("arm_W", 32'(w_out), 0);
    check("arm_valid", 32'(valid), 0);
    check("arm_start", start_cnt, 0);
    check("arm_busy", busy_cnt, 0);

    clear_mon(); send_pulse(400, 20);
    $display("pulse 400 -> W=%0d start=%0d", w_out, start_cnt);
    check("p400_W", 32'(w_out), 400);
    check("p400_start", start_cnt, 1);

    // reset 100 cycles into a 1000-cycle pulse
    @(posedge clk); #1 pulse_in = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("mid-pulse reset -> W=%0d valid=%0d busy=%0d", w_out, valid, busy);
    check("abort_W", 32'(w_out), 0);
    check("abort_valid", 32'(valid), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (897) @(posedge clk);
    #1 pulse_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("pulse tail after reset -> W=%0d start=%0d busy=%0d", w_out, start_cnt, busy_cnt);
    check("tail_start", start_cnt, 0);
    check("tail_busy", busy_cnt, 0);

    clear_mon(); send_pulse(50, 20);
    $display("pulse 50 -> W=%0d start=%0d", w_out, start_cnt);
    check("p50_W", 32'(w_out), 50);
    check("p50_start", start_cnt, 1);
    check("p50_valid", 32'(valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
